// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one UART transmitter between
//               NUM_REQ byte sources, with a start-acknowledge timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int START_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [8*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic [ID_W-1:0]       grant_id,
    output logic                  active,
    output logic                  tx_timeout
);

    localparam logic [1:0]      c_st_idle      = 2'd0;
    localparam logic [1:0]      c_st_wait_busy = 2'd1;
    localparam logic [1:0]      c_st_wait_done = 2'd2;
    localparam int              c_req_pad      = 2**ID_W;
    localparam logic [3:0]      c_timeout_last = 4'(START_TIMEOUT - 1);
    localparam logic [ID_W-1:0] c_last_rst     = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   c_num_req      = (ID_W+1)'(NUM_REQ);

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_grant_id;
    logic [3:0]         r_cnt;
    logic               r_tx_start;
    logic               r_timeout;
    logic [NUM_REQ-1:0] r_req_ack;
    logic [7:0]         r_tx_data;

    logic [c_req_pad-1:0] w_req_pad;
    logic [ID_W:0]        w_cand;
    logic [ID_W-1:0]      w_sel;
    logic                 w_sel_valid;
    logic [7:0]           w_sel_byte;
    logic [NUM_REQ-1:0]   w_sel_onehot;
    logic                 w_grant;

    // Walk candidates from farthest to nearest after last_grant so the
    // nearest pending requester is the one left standing.
    always_comb begin
        w_req_pad              = '0;
        w_req_pad[NUM_REQ-1:0] = req;
        w_sel                  = '0;
        w_sel_valid            = 1'b0;
        w_cand                 = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = {1'b0, r_last_grant} + (ID_W+1)'(k);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            if (w_req_pad[w_cand[ID_W-1:0]]) begin
                w_sel       = w_cand[ID_W-1:0];
                w_sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_byte   = '0;
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == ID_W'(i)) begin
                w_sel_byte      = req_data[8*i +: 8];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    assign w_grant = (r_state == c_st_idle) && !tx_busy && w_sel_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_last_grant <= c_last_rst;
            r_grant_id   <= '0;
            r_cnt        <= '0;
            r_tx_start   <= 1'b0;
            r_timeout    <= 1'b0;
            r_req_ack    <= '0;
            r_tx_data    <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_req_ack  <= '0;
            case (r_state)
                c_st_idle: begin
                    if (w_grant) begin
                        r_tx_data    <= w_sel_byte;
                        r_tx_start   <= 1'b1;
                        r_req_ack    <= w_sel_onehot;
                        r_grant_id   <= w_sel;
                        r_last_grant <= w_sel;
                        r_cnt        <= '0;
                        r_state      <= c_st_wait_busy;
                    end
                end
                c_st_wait_busy: begin
                    if (tx_busy) begin
                        r_state <= c_st_wait_done;
                    end else if (r_cnt == c_timeout_last) begin
                        r_timeout <= 1'b1;
                        r_state   <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_st_wait_done: begin
                    if (!tx_busy) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign req_ack    = r_req_ack;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign grant_id   = r_grant_id;
    assign active     = (r_state != c_st_idle);
    assign tx_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [IDW-1:0] grant_id;
    logic           active;
    logic           tx_timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .ID_W(IDW), .START_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
        .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
        step; step;
        reset = 1'b0;
    endtask

    // Steps until tx_start is seen; n = cycles waited, -1 if it never came.
    task automatic await_start(output int n);
        n = 0;
        while (!tx_start && n < 12) begin
            step;
            n++;
        end
        if (!tx_start) n = -1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({tx_start, req_ack, tx_data, grant_id, active, tx_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got start=%b ack=%b data=%h gid=%0d act=%b to=%b exp all zero",
                     tx_start, req_ack, tx_data, grant_id, active, tx_timeout);
        end
    endtask

    task automatic test_single;
        do_reset;
        req = 4'b0010; req_data = 32'h00_00_A5_00;
        step;
        checks++;
        if ({tx_start, req_ack, tx_data, grant_id, active} !== {1'b1, 4'b0010, 8'hA5, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_grant got start=%b ack=%b data=%h gid=%0d act=%b exp 1 0010 a5 1 1",
                     tx_start, req_ack, tx_data, grant_id, active);
        end
        req = '0; tx_busy = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step;
            checks++;
            if ({tx_start, req_ack, active} !== {1'b0, 4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL single_frame cyc%0d got start=%b ack=%b act=%b exp 0 0000 1",
                         j, tx_start, req_ack, active);
            end
        end
        tx_busy = 1'b0;
        step;
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL single_active_fall got=%b exp=0", active);
        end
    endtask

    task automatic test_round_robin;
        int n;
        int last_s;
        do_reset;
        req = 4'b1111; req_data = 32'h13_12_11_10;
        last_s = 0;
        for (int f = 0; f < 5; f++) begin
            await_start(n);
            checks++;
            if (n < 0 || tx_data !== 8'(8'h10 + f % 4) || req_ack !== 4'(1 << (f % 4))) begin
                errors++;
                $display("FAIL rr_frame%0d got wait=%0d data=%h ack=%b exp data=%h ack=%b",
                         f, n, tx_data, req_ack, 8'(8'h10 + f % 4), 4'(1 << (f % 4)));
            end
            if (f > 0) begin
                checks++;
                if (cyc - last_s != 3) begin
                    errors++;
                    $display("FAIL rr_spacing%0d got=%0d exp=3", f, cyc - last_s);
                end
            end
            last_s = cyc;
            tx_busy = 1'b1;
            step;
            checks++;
            if (req_ack !== 4'b0000 || tx_start !== 1'b0) begin
                errors++;
                $display("FAIL rr_single_ack%0d got ack=%b start=%b exp 0000 0", f, req_ack, tx_start);
            end
            tx_busy = 1'b0;
            step;
        end
    endtask

    task automatic test_fairness;
        int n;
        int s0;
        do_reset;
        req = 4'b0100; req_data = 32'h00_22_00_00;
        await_start(n);
        checks++;
        if (n < 0 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL fair_first got wait=%0d gid=%0d exp gid=2", n, grant_id);
        end
        req = '0; tx_busy = 1'b1;
        step;
        tx_busy = 1'b0; req = 4'b1001; req_data = 32'hB3_00_00_B0;
        step;
        await_start(n);
        checks++;
        if (n < 0 || grant_id !== 2'd3 || tx_data !== 8'hB3 || req_ack !== 4'b1000) begin
            errors++;
            $display("FAIL fair_to3 got wait=%0d gid=%0d data=%h ack=%b exp 3 b3 1000",
                     n, grant_id, tx_data, req_ack);
        end
        tx_busy = 1'b1; step; tx_busy = 1'b0; step;
        await_start(n);
        checks++;
        if (n < 0 || grant_id !== 2'd0 || tx_data !== 8'hB0) begin
            errors++;
            $display("FAIL fair_wrap0 got wait=%0d gid=%0d data=%h exp 0 b0", n, grant_id, tx_data);
        end
        s0 = cyc;
        req = 4'b0001; req_data = 32'h00_00_00_C0;
        tx_busy = 1'b1; step; tx_busy = 1'b0; step;
        await_start(n);
        checks++;
        if (n < 0 || grant_id !== 2'd0 || tx_data !== 8'hC0 || cyc - s0 != 3) begin
            errors++;
            $display("FAIL fair_repeat0 got gid=%0d data=%h spacing=%0d exp 0 c0 3",
                     grant_id, tx_data, cyc - s0);
        end
    endtask

    task automatic test_timeout;
        int n;
        do_reset;
        req = 4'b0001; req_data = 32'h00_00_00_5A;
        await_start(n);
        checks++;
        if (n < 0 || grant_id !== 2'd0 || tx_data !== 8'h5A) begin
            errors++;
            $display("FAIL to_grant got wait=%0d gid=%0d data=%h exp 0 5a", n, grant_id, tx_data);
        end
        req_data = 32'h00_00_00_5B;
        for (int j = 1; j <= TO; j++) begin
            step;
            checks++;
            if (active !== (j < TO) || tx_timeout !== (j == TO)) begin
                errors++;
                $display("FAIL to_count%0d got act=%b to=%b exp act=%b to=%b",
                         j, active, tx_timeout, (j < TO), (j == TO));
            end
        end
        step;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h5B || tx_timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_restart got start=%b data=%h to=%b exp 1 5b 1", tx_start, tx_data, tx_timeout);
        end
        req = '0;
        tx_busy = 1'b1; step; tx_busy = 1'b0; step;
        checks++;
        if (tx_timeout !== 1'b1 || active !== 1'b0) begin
            errors++;
            $display("FAIL to_sticky got to=%b act=%b exp 1 0", tx_timeout, active);
        end
    endtask

    task automatic test_busy_idle;
        reset = 1'b1; req = '0; req_data = 32'h00_77_00_00; tx_busy = 1'b1;
        step; step;
        reset = 1'b0; req = 4'b0100;
        for (int j = 0; j < 20; j++) begin
            step;
            checks++;
            if (tx_start !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL busy_idle_hold cyc%0d got start=%b act=%b exp 0 0", j, tx_start, active);
            end
        end
        tx_busy = 1'b0;
        step;
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd2 || req_ack !== 4'b0100 || tx_data !== 8'h77) begin
            errors++;
            $display("FAIL busy_idle_grant got start=%b gid=%0d ack=%b data=%h exp 1 2 0100 77",
                     tx_start, grant_id, req_ack, tx_data);
        end
        req = '0;
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset;
        req = 4'b0010; req_data = 32'h00_00_66_00;
        await_start(n);
        n = 0;
        while (!tx_timeout && n < 10) begin
            step;
            n++;
        end
        await_start(n);
        tx_busy = 1'b1;
        step;
        checks++;
        if (active !== 1'b1 || tx_timeout !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup got act=%b to=%b exp 1 1", active, tx_timeout);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({active, tx_start, tx_timeout, grant_id, tx_data, req_ack} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async got act=%b start=%b to=%b gid=%0d data=%h ack=%b exp all zero",
                     active, tx_start, tx_timeout, grant_id, tx_data, req_ack);
        end
        tx_busy = 1'b0; req = 4'b1111; req_data = 32'h44_33_22_11;
        step;
        reset = 1'b0;
        await_start(n);
        checks++;
        if (n < 0 || grant_id !== 2'd0 || req_ack !== 4'b0001 || tx_data !== 8'h11) begin
            errors++;
            $display("FAIL rst_mid_first got wait=%0d gid=%0d ack=%b data=%h exp 0 0001 11",
                     n, grant_id, req_ack, tx_data);
        end
    endtask

    task automatic test_random;
        int m_phase, m_wait, m_last, m_gid;
        logic m_to;
        logic [7:0] m_data;
        logic [N-1:0] in_req, e_ack;
        logic [8*N-1:0] in_data;
        logic in_busy, e_start;
        bit found;
        int x_delay, x_len;
        do_reset;
        m_phase = 0; m_wait = 0; m_last = N - 1; m_gid = 0; m_to = 1'b0; m_data = '0;
        x_delay = -1; x_len = 0;
        req = 4'($urandom);
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
        for (int c = 0; c < 400; c++) begin
            in_req = req; in_data = req_data; in_busy = tx_busy;
            step;
            // reference: phases 0=free, 1=awaiting busy, 2=frame in progress
            e_start = 1'b0; e_ack = '0;
            if (m_phase == 0) begin
                if (!in_busy && in_req != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && in_req[(m_last + k) % N]) begin
                            found  = 1'b1;
                            m_last = (m_last + k) % N;
                        end
                    end
                    m_gid = m_last; m_data = in_data[8*m_last +: 8];
                    e_start = 1'b1; e_ack[m_last] = 1'b1;
                    m_phase = 1; m_wait = 0;
                end
            end else if (m_phase == 1) begin
                if (in_busy) m_phase = 2;
                else begin
                    m_wait++;
                    if (m_wait == TO) begin m_to = 1'b1; m_phase = 0; end
                end
            end else if (!in_busy) begin
                m_phase = 0;
            end
            checks++;
            if ({tx_start, req_ack} !== {e_start, e_ack}) begin
                errors++;
                $display("FAIL rand_start_ack c%0d got %b/%b exp %b/%b", c, tx_start, req_ack, e_start, e_ack);
            end
            checks++;
            if (tx_data !== m_data || grant_id !== IDW'(m_gid)) begin
                errors++;
                $display("FAIL rand_data_gid c%0d got %h/%0d exp %h/%0d", c, tx_data, grant_id, m_data, m_gid);
            end
            checks++;
            if (active !== (m_phase != 0) || tx_timeout !== m_to) begin
                errors++;
                $display("FAIL rand_act_to c%0d got %b/%b exp %b/%b", c, active, tx_timeout, (m_phase != 0), m_to);
            end
            // transmitter: usually answers within 0..2 cycles, sometimes never
            if (tx_start) x_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 2));
            if (tx_busy) begin
                x_len--;
                if (x_len <= 0) tx_busy = 1'b0;
            end else if (x_delay == 0) begin
                tx_busy = 1'b1; x_len = int'($urandom_range(1, 6)); x_delay = -1;
            end else if (x_delay > 0) begin
                x_delay--;
            end
            for (int i = 0; i < N; i++) begin
                if (req_ack[i] || $urandom_range(0, 3) == 0) req[i] = 1'($urandom);
                req_data[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_fairness;
        test_timeout;
        test_busy_idle;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
